// File: rtl/cpu_req_queue.sv
// In-order CPU request queue in front of a memory controller.
// Throttles issued reads to MAX_RD outstanding and registers returning read data.
module cpu_req_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DM_W   = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned MAX_RD = 4
) (
  input  logic                        i_cpu_ck,
  input  logic                        i_cpu_reset,
  // CPU request side
  input  logic                        i_cpu_valid,
  input  logic                        i_cpu_cmd,
  input  logic [ADDR_W-1:0]           i_cpu_addr,
  input  logic [DATA_W-1:0]           i_cpu_wr_data,
  input  logic [DM_W-1:0]             i_cpu_dm,
  output logic                        o_cpu_data_rdy,
  // CPU read return
  output logic [DATA_W-1:0]           o_cpu_rd_data,
  output logic                        o_cpu_rd_data_valid,
  // Controller request side
  output logic                        o_mc_req_valid,
  output logic                        o_mc_req_cmd,
  output logic [ADDR_W-1:0]           o_mc_req_addr,
  output logic [DATA_W-1:0]           o_mc_req_wr_data,
  output logic [DM_W-1:0]             o_mc_req_dm,
  input  logic                        i_mc_req_ready,
  // Controller read return
  input  logic [DATA_W-1:0]           i_mc_rd_data,
  input  logic                        i_mc_rd_valid,
  // Status
  output logic [$clog2(DEPTH):0]      o_occupancy,
  output logic [$clog2(MAX_RD):0]     o_rd_outstanding,
  output logic                        o_err_unexp_rd
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned RD_W  = $clog2(MAX_RD) + 1;

  // Queue storage, intentionally not reset
  logic              mem_cmd  [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DM_W-1:0]   mem_dm   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occupancy_q, occupancy_d;
  logic [RD_W-1:0]   rd_out_q, rd_out_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_data_valid_q, rd_data_valid_d;
  logic              err_q, err_d;

  logic              empty;
  logic              ready_for_push;
  logic              head_cmd;
  logic              push;
  logic              pop;
  logic              rd_pop;
  logic              rd_unexp;
  logic              rd_accept;

  // Handshake decode, all from registered state plus current inputs
  always_comb begin
    empty          = (occupancy_q == '0);
    ready_for_push = (occupancy_q < CNT_W'(DEPTH));
    head_cmd       = mem_cmd[rd_ptr_q];
    push           = i_cpu_valid && ready_for_push;
    // A read at the head is held back while the controller already owns MAX_RD reads
    o_mc_req_valid = !empty && !(!head_cmd && (rd_out_q == RD_W'(MAX_RD)));
    pop            = o_mc_req_valid && i_mc_req_ready;
    rd_pop         = pop && !head_cmd;
    rd_unexp       = i_mc_rd_valid && (rd_out_q == '0);
    rd_accept      = i_mc_rd_valid && !rd_unexp;
  end

  // Next-state computation
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    occupancy_d     = occupancy_q;
    rd_out_d        = rd_out_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = rd_accept;
    err_d           = err_q || rd_unexp;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   occupancy_d = occupancy_q + CNT_W'(1);
      2'b01:   occupancy_d = occupancy_q - CNT_W'(1);
      default: occupancy_d = occupancy_q;
    endcase

    unique case ({rd_pop, rd_accept})
      2'b10:   rd_out_d = rd_out_q + RD_W'(1);
      2'b01:   rd_out_d = rd_out_q - RD_W'(1);
      default: rd_out_d = rd_out_q;
    endcase

    if (rd_accept) begin
      rd_data_d = i_mc_rd_data;
    end
  end

  always_ff @(posedge i_cpu_ck or posedge i_cpu_reset) begin
    if (i_cpu_reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occupancy_q     <= '0;
      rd_out_q        <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occupancy_q     <= occupancy_d;
      rd_out_q        <= rd_out_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      err_q           <= err_d;
    end
  end

  always_ff @(posedge i_cpu_ck) begin
    if (push) begin
      mem_cmd[wr_ptr_q]  <= i_cpu_cmd;
      mem_addr[wr_ptr_q] <= i_cpu_addr;
      mem_data[wr_ptr_q] <= i_cpu_wr_data;
      mem_dm[wr_ptr_q]   <= i_cpu_dm;
    end
  end

  always_comb begin
    o_cpu_data_rdy      = ready_for_push;
    o_mc_req_cmd        = head_cmd;
    o_mc_req_addr       = mem_addr[rd_ptr_q];
    o_mc_req_wr_data    = mem_data[rd_ptr_q];
    o_mc_req_dm         = mem_dm[rd_ptr_q];
    o_cpu_rd_data       = rd_data_q;
    o_cpu_rd_data_valid = rd_data_valid_q;
    o_occupancy         = occupancy_q;
    o_rd_outstanding    = rd_out_q;
    o_err_unexp_rd      = err_q;
  end

endmodule

// File: tb/tb_cpu_req_queue.sv
// Directed bench for cpu_req_queue with default parameters (DEPTH=8, MAX_RD=4).
module tb_cpu_req_queue;

  logic        clk;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_cmd;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wr_data;
  logic [7:0]  cpu_dm;
  logic        cpu_data_rdy;
  logic [63:0] cpu_rd_data;
  logic        cpu_rd_data_valid;
  logic        mc_req_valid;
  logic        mc_req_cmd;
  logic [31:0] mc_req_addr;
  logic [63:0] mc_req_wr_data;
  logic [7:0]  mc_req_dm;
  logic        mc_req_ready;
  logic [63:0] mc_rd_data;
  logic        mc_rd_valid;
  logic [3:0]  occupancy;
  logic [2:0]  rd_outstanding;
  logic        err_unexp_rd;

  int checks;
  int failures;

  cpu_req_queue dut (
    .i_cpu_ck            (clk),
    .i_cpu_reset         (rst),
    .i_cpu_valid         (cpu_valid),
    .i_cpu_cmd           (cpu_cmd),
    .i_cpu_addr          (cpu_addr),
    .i_cpu_wr_data       (cpu_wr_data),
    .i_cpu_dm            (cpu_dm),
    .o_cpu_data_rdy      (cpu_data_rdy),
    .o_cpu_rd_data       (cpu_rd_data),
    .o_cpu_rd_data_valid (cpu_rd_data_valid),
    .o_mc_req_valid      (mc_req_valid),
    .o_mc_req_cmd        (mc_req_cmd),
    .o_mc_req_addr       (mc_req_addr),
    .o_mc_req_wr_data    (mc_req_wr_data),
    .o_mc_req_dm         (mc_req_dm),
    .i_mc_req_ready      (mc_req_ready),
    .i_mc_rd_data        (mc_rd_data),
    .i_mc_rd_valid       (mc_rd_valid),
    .o_occupancy         (occupancy),
    .o_rd_outstanding    (rd_outstanding),
    .o_err_unexp_rd      (err_unexp_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    cpu_valid    = 1'b0;
    cpu_cmd      = 1'b0;
    cpu_addr     = '0;
    cpu_wr_data  = '0;
    cpu_dm       = '0;
    mc_req_ready = 1'b0;
    mc_rd_data   = '0;
    mc_rd_valid  = 1'b0;
    tick();
    tick();
    chk("reset_occ", occupancy, 0);
    chk("reset_rdout", rd_outstanding, 0);
    chk("reset_rdy", cpu_data_rdy, 1);
    chk("reset_mcvalid", mc_req_valid, 0);
    chk("reset_err", err_unexp_rd, 0);
    chk("reset_rdvalid", cpu_rd_data_valid, 0);
    chk("reset_rddata", cpu_rd_data, 0);
    rst = 1'b0;
    tick();

    // Single write
    cpu_valid    = 1'b1;
    cpu_cmd      = 1'b1;
    cpu_addr     = 32'h10;
    cpu_wr_data  = 64'hA5A5_A5A5_A5A5_A5A5;
    cpu_dm       = 8'h3C;
    mc_req_ready = 1'b1;
    #1;
    chk("wr_not_passthru", mc_req_valid, 0);
    tick();
    cpu_valid = 1'b0;
    #1;
    chk("wr_valid", mc_req_valid, 1);
    chk("wr_cmd", mc_req_cmd, 1);
    chk("wr_addr", mc_req_addr, 32'h10);
    chk("wr_data", mc_req_wr_data, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("wr_dm", mc_req_dm, 8'h3C);
    chk("wr_occ1", occupancy, 1);
    tick();
    chk("wr_occ0", occupancy, 0);
    chk("wr_drained", mc_req_valid, 0);

    // Fill with ready low; ninth push must be dropped
    mc_req_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cpu_valid   = 1'b1;
      cpu_cmd     = 1'b1;
      cpu_addr    = 32'h100 + 32'(i);
      cpu_wr_data = 64'(i);
      cpu_dm      = 8'hFF;
      tick();
      if (i == 7) chk("fill_rdy_low", cpu_data_rdy, 0);
    end
    cpu_valid = 1'b0;
    chk("fill_occ", occupancy, 8);
    chk("fill_hold_addr", mc_req_addr, 32'h100);
    mc_req_ready = 1'b1;
    #1;
    for (int j = 0; j < 8; j++) begin
      chk("fill_drain_valid", mc_req_valid, 1);
      chk("fill_drain_addr", mc_req_addr, 32'h100 + 32'(j));
      chk("fill_drain_data", mc_req_wr_data, 64'(j));
      tick();
    end
    chk("fill_no_ninth", mc_req_valid, 0);
    chk("fill_occ0", occupancy, 0);

    // Read throttle: five reads, only four issue
    mc_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_valid = 1'b1;
      cpu_cmd   = 1'b0;
      cpu_addr  = 32'h200 + 32'(i);
      tick();
    end
    cpu_valid    = 1'b0;
    mc_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("thr_blocked", mc_req_valid, 0);
    chk("thr_rdout4", rd_outstanding, 4);
    chk("thr_occ1", occupancy, 1);
    mc_rd_valid = 1'b1;
    mc_rd_data  = 64'hDEAD;
    tick();
    mc_rd_valid = 1'b0;
    chk("thr_rdvalid", cpu_rd_data_valid, 1);
    chk("thr_rddata", cpu_rd_data, 64'hDEAD);
    chk("thr_rdout3", rd_outstanding, 3);
    chk("thr_fifth_valid", mc_req_valid, 1);
    chk("thr_fifth_addr", mc_req_addr, 32'h204);
    tick();
    chk("thr_pulse_end", cpu_rd_data_valid, 0);
    chk("thr_data_hold", cpu_rd_data, 64'hDEAD);
    chk("thr_rdout4b", rd_outstanding, 4);
    chk("thr_occ0", occupancy, 0);
    mc_rd_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      mc_rd_data = 64'(i);
      tick();
    end
    mc_rd_valid = 1'b0;
    chk("thr_last_data", cpu_rd_data, 4);
    chk("thr_rdout0", rd_outstanding, 0);
    chk("thr_err0", err_unexp_rd, 0);

    // Read pop and read return in the same cycle
    mc_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_valid = 1'b1;
      cpu_cmd   = 1'b0;
      cpu_addr  = 32'h300 + 32'(i);
      tick();
    end
    cpu_valid    = 1'b0;
    mc_req_ready = 1'b1;
    tick();
    tick();
    chk("sim_rdout2", rd_outstanding, 2);
    mc_rd_valid = 1'b1;
    mc_rd_data  = 64'h55;
    tick();
    chk("sim_rdout_hold", rd_outstanding, 2);
    chk("sim_occ0", occupancy, 0);
    tick();
    tick();
    mc_rd_valid = 1'b0;
    chk("sim_rdout0", rd_outstanding, 0);

    // Push and pop in the same cycle
    mc_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_valid = 1'b1;
      cpu_cmd   = 1'b1;
      cpu_addr  = 32'h400 + 32'(i);
      tick();
    end
    chk("pp_occ3", occupancy, 3);
    cpu_addr     = 32'h403;
    mc_req_ready = 1'b1;
    tick();
    cpu_valid = 1'b0;
    chk("pp_occ_hold", occupancy, 3);
    chk("pp_head", mc_req_addr, 32'h401);
    for (int i = 0; i < 3; i++) tick();
    chk("pp_occ0", occupancy, 0);

    // Unexpected read return
    mc_rd_valid = 1'b1;
    mc_rd_data  = 64'hBEEF;
    tick();
    mc_rd_valid = 1'b0;
    chk("err_set", err_unexp_rd, 1);
    chk("err_no_pulse", cpu_rd_data_valid, 0);
    chk("err_rdout0", rd_outstanding, 0);
    chk("err_data_hold", cpu_rd_data, 64'h55);
    tick();
    tick();
    chk("err_sticky", err_unexp_rd, 1);

    // Reset in the middle of traffic
    mc_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_valid = 1'b1;
      cpu_cmd   = 1'b0;
      cpu_addr  = 32'h500 + 32'(i);
      tick();
    end
    cpu_valid    = 1'b0;
    mc_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mc_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_valid = 1'b1;
      cpu_cmd   = 1'b1;
      cpu_addr  = 32'h600 + 32'(i);
      tick();
    end
    cpu_valid = 1'b0;
    chk("mid_occ5", occupancy, 5);
    chk("mid_rdout3", rd_outstanding, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_rdout", rd_outstanding, 0);
    chk("arst_err", err_unexp_rd, 0);
    chk("arst_rddata", cpu_rd_data, 0);
    chk("arst_rdy", cpu_data_rdy, 1);
    chk("arst_mcvalid", mc_req_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_occ", occupancy, 0);
    mc_rd_valid = 1'b1;
    mc_rd_data  = 64'h77;
    tick();
    mc_rd_valid = 1'b0;
    chk("post_rst_err", err_unexp_rd, 1);
    chk("post_rst_no_pulse", cpu_rd_data_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_req_queue.md
CPU_REQ_QUEUE -- requirements
Module: cpu_req_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, CPU request address width.
REQ-002 SHALL have parameter DATA_W, default 64 (8*DQ_BITS), write/read data width.
REQ-003 SHALL have parameter DM_W, default 8 (BURST_L), data-mask width, one bit per burst beat.
REQ-004 SHALL have parameter DEPTH, default 8, power of two and at least 2, request queue entries.
REQ-005 SHALL have parameter MAX_RD, default 4, at least 1, maximum reads issued to the controller and not yet returned.
REQ-006 SHALL have ports i_cpu_ck (in, 1, clock) and i_cpu_reset (in, 1, asynchronous active-high reset).
REQ-007 SHALL have CPU request ports i_cpu_valid (in, 1), i_cpu_cmd (in, 1; 1=write, 0=read), i_cpu_addr (in, ADDR_W), i_cpu_wr_data (in, DATA_W) and i_cpu_dm (in, DM_W).
REQ-008 SHALL have o_cpu_data_rdy (out, 1): the queue can accept a request this cycle.
REQ-009 SHALL have CPU return ports o_cpu_rd_data (out, DATA_W) and o_cpu_rd_data_valid (out, 1).
REQ-010 SHALL have controller request ports o_mc_req_valid (out, 1), o_mc_req_cmd (out, 1), o_mc_req_addr (out, ADDR_W), o_mc_req_wr_data (out, DATA_W), o_mc_req_dm (out, DM_W) and i_mc_req_ready (in, 1).
REQ-011 SHALL have controller return ports i_mc_rd_data (in, DATA_W) and i_mc_rd_valid (in, 1).
REQ-012 SHALL have status ports o_occupancy (out, $clog2(DEPTH)+1), o_rd_outstanding (out, $clog2(MAX_RD)+1) and o_err_unexp_rd (out, 1, sticky).

Function
REQ-013 SHALL drive o_cpu_data_rdy = (occupancy < DEPTH), combinationally from registered state only.
REQ-014 SHALL push {cmd, addr, wr_data, dm} into the tail on each rising edge where i_cpu_valid && o_cpu_data_rdy; requests presented while not ready are ignored.
REQ-015 SHALL present the head entry on the o_mc_req_* ports; a pushed entry becomes visible there no earlier than the cycle after the push.
REQ-016 SHALL drive o_mc_req_valid = !empty && !(head is read && rd_outstanding == MAX_RD).
REQ-017 SHALL pop the head on each edge where o_mc_req_valid && i_mc_req_ready, preserving strict CPU order for reads and writes.
REQ-018 SHALL update occupancy as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-019 SHALL accept a push in the same cycle as a pop only if the queue was not full at the start of that cycle; there is no pass-through when full.
REQ-020 SHALL update rd_outstanding as +1 on a read pop, -1 on an accepted i_mc_rd_valid, and unchanged when both occur in the same cycle.
REQ-021 SHALL, on i_mc_rd_valid, register i_mc_rd_data to o_cpu_rd_data and pulse o_cpu_rd_data_valid high for exactly one cycle, one cycle later (latency 1).
REQ-022 SHALL hold o_cpu_rd_data at its last value while o_cpu_rd_data_valid is low.
REQ-023 SHALL, on i_mc_rd_valid while rd_outstanding == 0, set o_err_unexp_rd, leave the counter at 0, and not pulse o_cpu_rd_data_valid.
REQ-024 SHALL keep o_err_unexp_rd set until reset.
REQ-025 SHALL keep o_mc_req_* fields stable while o_mc_req_valid is high and i_mc_req_ready is low.

Reset
REQ-026 SHALL, on i_cpu_reset high, asynchronously clear the pointers, occupancy, rd_outstanding, o_cpu_rd_data_valid, o_cpu_rd_data (to 0) and o_err_unexp_rd; o_mc_req_valid is then 0 and o_cpu_data_rdy is 1.
REQ-027 SHALL discard all queued entries and outstanding-read tracking on reset mid-operation; read data returning after reset deassertion with the counter at 0 sets o_err_unexp_rd.
REQ-028 SHALL leave queue storage contents unreset; they are don't-care.

Verification
REQ-029 Single write: push write addr=0x10, data=0xA5A5_A5A5_A5A5_A5A5, with i_mc_req_ready=1 -> o_mc_req_valid high in the next cycle with matching fields, then popped; occupancy returns to 0.
REQ-030 Fill: DEPTH=8, i_mc_req_ready=0, nine pushes -> o_cpu_data_rdy low after the 8th push, the 9th is dropped, occupancy=8; release ready -> eight requests in order, the 9th never appears.
REQ-031 Read throttle: MAX_RD=4, five queued reads, no returns -> four pop, then o_mc_req_valid=0 and rd_outstanding=4; one i_mc_rd_valid with 0xDEAD -> o_cpu_rd_data_valid one cycle later carrying 0xDEAD, and the 5th read issues.
REQ-032 Simultaneous events: read pop and i_mc_rd_valid in the same cycle with rd_outstanding=2 -> stays 2; push and pop in the same cycle with occupancy=3 -> stays 3.
REQ-033 Error: i_mc_rd_valid with rd_outstanding=0 -> o_err_unexp_rd=1, no o_cpu_rd_data_valid pulse, counter stays 0; flag clears only on i_cpu_reset.
REQ-034 Reset mid-traffic: occupancy=5, rd_outstanding=3, assert i_cpu_reset between clock edges -> all status outputs read 0 immediately, o_cpu_data_rdy=1, o_mc_req_valid=0.
